// File: rtl/mult_div_if.sv
// Handshake and data bundle between the EX stage and the multiply/divide unit.
// The master drives the operands and control inputs; the slave returns HI/LO and status.
interface mult_div_if #(
  parameter int N = 32
);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         mthi;
  logic         mtlo;
  logic [N-1:0] mt_data;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, op, a, b, mthi, mtlo, mt_data,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, mt_data,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Works on magnitudes for N cycles, then applies the sign fixup on the FINISH edge.
module mult_div_unit #(
  parameter int N = 32
) (
  input logic      clk,
  input logic      rst,
  mult_div_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] acc_q;
  logic [N-1:0]   opnd_q;
  logic [N-1:0]   a_raw_q;
  logic [N-1:0]   hi_q;
  logic [N-1:0]   lo_q;
  logic           is_div_q;
  logic           neg_lo_q;
  logic           neg_hi_q;
  logic           b_zero_q;
  logic           busy_q;
  logic           done_q;
  logic           dbz_q;

  logic           a_neg;
  logic           b_neg;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  logic [N:0]     div_shift;
  logic [N:0]     div_diff;
  logic           div_ok;
  logic [2*N-1:0] div_next;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix;
  logic [N-1:0]   rem_fix;

  // op[0] set means unsigned, so only signed ops look at the operand sign bits
  assign a_neg = ~bus.op[0] & bus.a[N-1];
  assign b_neg = ~bus.op[0] & bus.b[N-1];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
  assign mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[N-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, restoring one quotient bit per step
  assign div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ok    = ~div_diff[N];
  assign div_next  = {(div_ok ? div_diff[N-1:0] : div_shift[N-1:0]), acc_q[N-2:0], div_ok};

  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quo_fix  = neg_lo_q ? -acc_q[N-1:0] : acc_q[N-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      b_zero_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            acc_q    <= {{N{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
            opnd_q   <= bus.op[1] ? b_mag : a_mag;
            a_raw_q  <= bus.a;
            is_div_q <= bus.op[1];
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            b_zero_q <= (bus.b == '0);
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            dbz_q    <= 1'b0;
            state_q  <= S_RUN;
          end else begin
            if (bus.mthi) hi_q <= bus.mt_data;
            if (bus.mtlo) lo_q <= bus.mt_data;
          end
        end
        S_RUN: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N-1)) state_q <= S_FINISH;
        end
        S_FINISH: begin
          if (is_div_q) begin
            if (b_zero_q) begin
              lo_q  <= '1;
              hi_q  <= a_raw_q;
              dbz_q <= 1'b1;
            end else begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/flag are queued at launch
// and popped when done pulses; latency, busy window and reject rules are checked inline.
module tb_mult_div_unit;
  localparam int N = 32;

  logic clk;
  logic rst;
  int   assert_cnt = 0;
  int   fail_cnt   = 0;

  logic [N-1:0] model_hi;
  logic [N-1:0] model_lo;
  logic [N-1:0] exp_hi_q[$];
  logic [N-1:0] exp_lo_q[$];
  bit           exp_dbz_q[$];

  mult_div_if #(.N(N)) bus ();

  mult_div_unit #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output bit z);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = longint'(a);
    longint unsigned ub = longint'(b);
    logic [63:0]     p;
    z = 1'b0;
    h = '0;
    l = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = 64'(ua * ub); h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF; z = 1'b1;
        end else if (op == 2'b10) begin
          l = 32'(sa / sb); h = 32'(sa % sb);
        end else begin
          l = 32'(ua / ub); h = 32'(ua % ub);
        end
      end
    endcase
  endfunction

  // mode: 0 plain, 1 start+mthi pulsed mid-operation, 2 mtlo driven together with start
  task automatic do_op(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                       input int mode, input string tag);
    logic [31:0] eh, el, gh, gl;
    bit          ed, gd, busy_bad;
    int          n;
    model(op_v, a_v, b_v, eh, el, ed);
    exp_hi_q.push_back(eh);
    exp_lo_q.push_back(el);
    exp_dbz_q.push_back(ed);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op_v; bus.a = a_v; bus.b = b_v;
    if (mode == 2) begin bus.mtlo = 1'b1; bus.mt_data = 32'hABCD_0123; end
    @(negedge clk);
    bus.start = 1'b0; bus.mtlo = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    n = 0;
    busy_bad = 1'b0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy !== 1'b1) busy_bad = 1'b1;
      if (mode == 1 && n == 5) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.mthi = 1'b1; bus.mt_data = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0; bus.mthi = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0; bus.mthi = 1'b0;
    gh = exp_hi_q.pop_front();
    gl = exp_lo_q.pop_front();
    gd = exp_dbz_q.pop_front();
    assert_cnt++;
    if (n != N + 1) begin
      fail_cnt++;
      $display("FAIL %s latency: got %0d edges, expected %0d", tag, n, N + 1);
    end
    assert_cnt++;
    if (busy_bad || bus.busy !== 1'b0) begin
      fail_cnt++;
      $display("FAIL %s busy window: dropped early=%0b, at done busy=%b expected 0", tag, busy_bad, bus.busy);
    end
    assert_cnt++;
    if (bus.hi !== gh || bus.lo !== gl) begin
      fail_cnt++;
      $display("FAIL %s result: hi=%h lo=%h expected hi=%h lo=%h", tag, bus.hi, bus.lo, gh, gl);
    end
    assert_cnt++;
    if (bus.div_by_zero !== gd) begin
      fail_cnt++;
      $display("FAIL %s div_by_zero: got %b expected %b", tag, bus.div_by_zero, gd);
    end
    $display("op %s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b after %0d edges",
             tag, op_v, a_v, b_v, bus.hi, bus.lo, bus.div_by_zero, n);
    @(negedge clk);
    assert_cnt++;
    if (bus.done !== 1'b0 || bus.hi !== gh || bus.lo !== gl) begin
      fail_cnt++;
      $display("FAIL %s hold after done: done=%b hi=%h lo=%h expected done=0 hi=%h lo=%h",
               tag, bus.done, bus.hi, bus.lo, gh, gl);
    end
    model_hi = gh;
    model_lo = gl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    assert_cnt++;
    if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset state: hi=%h lo=%h busy=%b done=%b dbz=%b expected all zero",
               bus.hi, bus.lo, bus.busy, bus.done, bus.div_by_zero);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_hi = '0;
    model_lo = '0;
  endtask

  task automatic test_multiply();
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, "mult_neg3x5");
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, "mult_minxmin");
    for (int i = 0; i < 3; i++) begin
      do_op(2'(i % 2), $urandom, $urandom, 0, "mult_rand");
    end
  endtask

  task automatic test_divide();
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "div_neg7by2");
    do_op(2'b11, 32'd7, 32'd2, 0, "divu_7by2");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_overflow");
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, "div_7byneg2");
    for (int i = 0; i < 3; i++) begin
      do_op(2'b10 + 2'(i % 2), $urandom, $urandom_range(1, 32'h000F_FFFF), 0, "div_rand");
    end
  endtask

  task automatic test_div_by_zero();
    do_op(2'b11, 32'd5, 32'd0, 0, "divu_by_zero");
    do_op(2'b01, 32'd2, 32'd3, 0, "multu_clears_dbz");
    do_op(2'b10, 32'hFFFF_FF00, 32'd0, 0, "div_by_zero_signed");
  endtask

  task automatic test_reject();
    do_op(2'b11, 32'd1000, 32'd9, 1, "reject_while_busy");
  endtask

  task automatic test_mt();
    do_op(2'b01, 32'd11, 32'd13, 2, "start_beats_mtlo");
    @(negedge clk);
    bus.mtlo = 1'b1; bus.mt_data = 32'h0000_1234;
    @(negedge clk);
    bus.mtlo = 1'b0;
    model_lo = 32'h0000_1234;
    assert_cnt++;
    if (bus.lo !== model_lo || bus.hi !== model_hi || bus.done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL mtlo_alone: lo=%h hi=%h done=%b expected lo=%h hi=%h done=0",
               bus.lo, bus.hi, bus.done, model_lo, model_hi);
    end
    $display("op mtlo data=00001234 -> hi=%h lo=%h", bus.hi, bus.lo);
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'h55AA_33CC;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    model_hi = 32'h55AA_33CC;
    model_lo = 32'h55AA_33CC;
    assert_cnt++;
    if (bus.hi !== model_hi || bus.lo !== model_lo || bus.done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL mthi_mtlo_both: hi=%h lo=%h done=%b expected hi=%h lo=%h done=0",
               bus.hi, bus.lo, bus.done, model_hi, model_lo);
    end
    $display("op mthi+mtlo data=55aa33cc -> hi=%h lo=%h", bus.hi, bus.lo);
  endtask

  task automatic test_abort();
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    assert_cnt++;
    if (bus.busy !== 1'b0 || bus.hi !== '0 || bus.lo !== '0 || bus.done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL abort_reset: busy=%b hi=%h lo=%h done=%b expected 0 0 0 0",
               bus.busy, bus.hi, bus.lo, bus.done);
    end
    $display("op rst mid-DIV -> busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    @(negedge clk);
    rst = 1'b0;
    model_hi = '0;
    model_lo = '0;
    do_op(2'b11, 32'd100, 32'd7, 0, "divu_after_abort");
  endtask

  task automatic test_back_to_back();
    do_op(2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, "b2b_mult");
    do_op(2'b10, 32'hFFFF_FF9C, 32'd7, 0, "b2b_div");
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.mt_data = '0;
    test_reset();
    test_multiply();
    test_divide();
    test_div_by_zero();
    test_reject();
    test_mt();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
